// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator: each channel emits a one-cycle tick and a square wave
// every div_act+1 clocks, with shadowed divisor writes so period changes never glitch.
module multi_tick_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DEFAULT_DIV = 833333,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq_out
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  div_act_q [NUM_CH];
    logic [CNT_W-1:0]  div_act_d [NUM_CH];
    logic [CNT_W-1:0]  div_shd_q [NUM_CH];
    logic [CNT_W-1:0]  div_shd_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] sq_q, sq_d;

    assign tick   = tick_q;
    assign sq_out = sq_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_act_d[i] = div_act_q[i];
            div_shd_d[i] = div_shd_q[i];
            tick_d[i]    = 1'b0;
            sq_d[i]      = sq_q[i];

            // Out-of-range wr_ch matches no channel, so such writes vanish.
            if (wr_en && (wr_ch == CH_W'(i)))
                div_shd_d[i] = wr_data;

            // div_act always loads the pre-write shadow, delaying a same-cycle write by one load.
            if (sync || !en[i]) begin
                cnt_d[i]     = '0;
                sq_d[i]      = 1'b0;
                div_act_d[i] = div_shd_q[i];
            end else if (cnt_q[i] == div_act_q[i]) begin
                cnt_d[i]     = '0;
                tick_d[i]    = 1'b1;
                sq_d[i]      = ~sq_q[i];
                div_act_d[i] = div_shd_q[i];
            end else begin
                cnt_d[i]     = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                div_act_q[i] <= DEF_DIV;
                div_shd_q[i] <= DEF_DIV;
            end
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                div_act_q[i] <= div_act_d[i];
                div_shd_q[i] <= div_shd_d[i];
            end
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen: a 2-channel and a 3-channel instance are driven
// each cycle, a behavioural model pushes expected outputs, a negedge monitor compares them.
module tb_multi_tick_gen;

    logic       clk_in  = 1'b0;
    logic       reset   = 1'b0;
    logic       sync    = 1'b0;
    logic       wr_en   = 1'b0;
    logic       wr_en3  = 1'b0;
    logic [1:0] en      = 2'b00;
    logic       wr_ch   = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic [2:0] en3     = 3'b000;
    logic [1:0] wr_ch3  = 2'd0;
    logic [1:0] tick, sq_out;
    logic [2:0] tick3, sq3;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [1:0] t2;
        logic [1:0] s2;
        logic [2:0] t3;
        logic [2:0] s3;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Model state: entries 0..1 belong to the 2-channel DUT, 2..4 to the 3-channel DUT.
    logic [3:0] m_cnt [5];
    logic [3:0] m_act [5];
    logic [3:0] m_shd [5];
    logic       m_tick[5];
    logic       m_sq  [5];

    multi_tick_gen #(.NUM_CH(2), .CNT_W(4), .DEFAULT_DIV(3)) u_dut (
        .clk_in(clk_in), .reset(reset), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .tick(tick), .sq_out(sq_out)
    );

    multi_tick_gen #(.NUM_CH(3), .CNT_W(4), .DEFAULT_DIV(3)) u_dut3 (
        .clk_in(clk_in), .reset(reset), .en(en3), .sync(sync),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data),
        .tick(tick3), .sq_out(sq3)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_ch(input int k, input logic en_b, input logic hit, input logic [3:0] d);
        logic [3:0] old_shd;
        old_shd = m_shd[k];
        if (!reset) begin
            m_cnt[k] = 4'd0; m_tick[k] = 1'b0; m_sq[k] = 1'b0;
            m_act[k] = 4'd3; m_shd[k] = 4'd3;
            return;
        end
        if (hit) m_shd[k] = d;
        if (sync || !en_b) begin
            m_cnt[k] = 4'd0; m_tick[k] = 1'b0; m_sq[k] = 1'b0; m_act[k] = old_shd;
        end else if (m_cnt[k] == m_act[k]) begin
            m_cnt[k] = 4'd0; m_tick[k] = 1'b1; m_sq[k] = ~m_sq[k]; m_act[k] = old_shd;
        end else begin
            m_cnt[k] = m_cnt[k] + 4'd1; m_tick[k] = 1'b0;
        end
    endtask

    // Predict the effect of the coming edge, queue it, then advance one clock.
    task automatic step();
        exp_t e;
        for (int k = 0; k < 2; k++)
            model_ch(k, en[k], wr_en && (wr_ch == 1'(k)), wr_data);
        for (int c = 0; c < 3; c++)
            model_ch(c + 2, en3[c], wr_en3 && (wr_ch3 == 2'(c)), wr_data);
        e.t2 = {m_tick[1], m_tick[0]};
        e.s2 = {m_sq[1], m_sq[0]};
        e.t3 = {m_tick[4], m_tick[3], m_tick[2]};
        e.s3 = {m_sq[4], m_sq[3], m_sq[2]};
        sb.push_back(e);
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_cnt(input int k, input logic [3:0] v);
        for (int i = 0; i < 40 && m_cnt[k] != v; i++) step();
        check("wait_cnt", 32'(m_cnt[k]), 32'(v));
    endtask

    always @(negedge clk_in) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("tick",   32'(tick),   32'(mon_e.t2));
            check("sq_out", 32'(sq_out), 32'(mon_e.s2));
            check("tick3",  32'(tick3),  32'(mon_e.t3));
            check("sq3",    32'(sq3),    32'(mon_e.s3));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int n0, n1, n3, both;

        // 1: reset, then run both channels at the default divisor
        repeat (2) step();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_sq",   32'(sq_out), 32'd0);
        reset = 1'b1; en = 2'b11; en3 = 3'b111;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (tick[0] && first == 0) first = i;
        end
        check("first_tick", 32'(first), 32'd4);

        // 2: ch1 divisor 1 written mid-period
        wait_cnt(1, 4'd1);
        wr_en = 1'b1; wr_ch = 1'b1; wr_data = 4'd1;
        step();
        wr_en = 1'b0;
        repeat (10) step();

        // 3: ch0 divisor 0 written exactly on the wrap cycle
        for (int i = 0; i < 40 && m_cnt[0] != m_act[0]; i++) step();
        check("wait_wrap", 32'(m_cnt[0]), 32'(m_act[0]));
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 4'd0;
        step();
        wr_en = 1'b0;
        repeat (8) step();
        n0 = 0;
        repeat (4) begin step(); n0 += int'(tick[0]); end
        check("cont_tick", 32'(n0), 32'd4);

        // 4: disable ch0 mid-count, write divisor 5, re-enable
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 4'd3;
        step();
        wr_en = 1'b0;
        step();
        wait_cnt(0, 4'd2);
        en[0] = 1'b0;
        step();
        check("dis_tick", 32'(tick[0]), 32'd0);
        check("dis_sq",   32'(sq_out[0]), 32'd0);
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 4'd5;
        step();
        wr_en = 1'b0;
        step();
        en[0] = 1'b1;
        first = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (tick[0] && first == 0) first = i;
        end
        check("reen_tick", 32'(first), 32'd6);

        // 5: divisors 2 and 5 at offset phases, then sync
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 4'd2;
        step();
        wr_ch = 1'b1; wr_data = 4'd5;
        step();
        wr_en = 1'b0;
        repeat (5) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_sq",   32'(sq_out), 32'd0);
        check("sync_tick", 32'(tick), 32'd0);
        both = 0;
        repeat (18) begin step(); both += int'(tick == 2'b11); end
        check("coincide", 32'(both), 32'd3);

        // 6: reset with pending writes, then an out-of-range write on the 3-channel DUT
        wait_cnt(0, 4'd1);
        wr_en = 1'b1; wr_ch = 1'b1; wr_data = 4'd7;
        step();
        reset = 1'b0; wr_ch = 1'b0; wr_data = 4'd9;
        step();
        wr_en = 1'b0;
        check("rst2_tick", 32'(tick), 32'd0);
        check("rst2_sq",   32'(sq_out), 32'd0);
        reset = 1'b1;
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data = 4'd0;
        step();
        wr_en3 = 1'b0;
        n0 = 0; n1 = 0; n3 = 0;
        repeat (11) begin
            step();
            n0 += int'(tick[0]);
            n1 += int'(tick[1]);
            n3 += int'(tick3[0]) + int'(tick3[1]) + int'(tick3[2]);
        end
        check("rst_div0", 32'(n0), 32'd3);
        check("rst_div1", 32'(n1), 32'd3);
        check("oor_write", 32'(n3), 32'd9);

        @(negedge clk_in);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
